// File: rtl/png_chunk_crc_chk_pkg.sv
// Shared constants, FSM encoding and CRC helpers for the PNG chunk CRC checker.
// The CRC register runs MSB-first; crc32_final maps it to the PNG field layout.
package png_chunk_crc_chk_pkg;

    localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;
    localparam logic [31:0] PNG_MAX_LEN  = 32'h7FFF_FFFF;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_CRC = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_TYPE,
        ST_DATA,
        ST_SCRC,
        ST_DONE
    } chk_state_e;

    function automatic logic [31:0] crc32_final(input logic [31:0] c);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = c[31-i];
        end
        return r ^ CRC32_XOROUT;
    endfunction

endpackage

// File: rtl/png_chunk_crc_chk_crc32_upd8.sv
// Combinational CRC-32 step over one byte; the byte enters LSB first, which is
// the bit-reflected input ordering PNG uses.
module crc32_upd8
    import png_chunk_crc_chk_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  dat,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ dat[i]) begin
                c = {c[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/png_chunk_crc_chk.sv
// Receive-side PNG chunk checker: parses length/type/data/CRC words and verifies the CRC.
// Define CRC_PAR4_EN for a word-per-cycle digest; the default build digests one byte per cycle.
module png_chunk_crc_chk
    import png_chunk_crc_chk_pkg::*;
#(
    parameter logic [31:0] MAX_LEN = PNG_MAX_LEN,
    parameter int          DATA_WD = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               val_i,
    input  logic [DATA_WD-1:0] dat_i,
    output logic               rdy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [1:0]         err_code_o,
    output logic [DATA_WD-1:0] typ_o,
    output logic [DATA_WD-1:0] len_o,
    output logic [DATA_WD-1:0] crc_o
);

    chk_state_e  state;
    logic [31:0] crc_reg;
    logic [31:0] rem;
    logic [1:0]  err_pend;

    logic        acc;
    logic        dig_en;
    logic [31:0] crc_upd;

    assign acc = val_i && rdy_o;

`ifdef CRC_PAR4_EN
    logic [31:0] crc_s1, crc_s2, crc_s3, crc_s4;
    logic [2:0]  nbytes;

    crc32_upd8 u_upd0 (.crc_in(crc_reg), .dat(dat_i[31:24]), .crc_out(crc_s1));
    crc32_upd8 u_upd1 (.crc_in(crc_s1),  .dat(dat_i[23:16]), .crc_out(crc_s2));
    crc32_upd8 u_upd2 (.crc_in(crc_s2),  .dat(dat_i[15:8]),  .crc_out(crc_s3));
    crc32_upd8 u_upd3 (.crc_in(crc_s3),  .dat(dat_i[7:0]),   .crc_out(crc_s4));

    // The last data word may carry 1..3 real bytes; tap the chain accordingly.
    always_comb begin
        nbytes = 3'd4;
        if (state == ST_DATA && rem < 32'd4) begin
            nbytes = rem[2:0];
        end
        case (nbytes)
            3'd1:    crc_upd = crc_s1;
            3'd2:    crc_upd = crc_s2;
            3'd3:    crc_upd = crc_s3;
            default: crc_upd = crc_s4;
        endcase
        dig_en = acc && (state == ST_TYPE || state == ST_DATA);
    end
`else
    logic [1:0]  slot;
    logic [23:0] wbuf;
    logic [7:0]  byte_sel;

    // Slot 0 digests the top byte straight off the bus in the accept cycle.
    always_comb begin
        case (slot)
            2'd0:    byte_sel = dat_i[31:24];
            2'd1:    byte_sel = wbuf[23:16];
            2'd2:    byte_sel = wbuf[15:8];
            default: byte_sel = wbuf[7:0];
        endcase
        dig_en = (state == ST_TYPE || state == ST_DATA) && (slot != 2'd0 || acc);
    end

    crc32_upd8 u_upd (.crc_in(crc_reg), .dat(byte_sel), .crc_out(crc_upd));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            crc_reg    <= '0;
            rem        <= '0;
            err_pend   <= ERR_OK;
            rdy_o      <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ERR_OK;
            typ_o      <= '0;
            len_o      <= '0;
            crc_o      <= '0;
`ifndef CRC_PAR4_EN
            slot       <= 2'd0;
            wbuf       <= '0;
`endif
        end else begin
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ERR_OK;

            if (dig_en) begin
                crc_reg <= crc_upd;
                crc_o   <= crc32_final(crc_upd);
            end

            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        crc_reg  <= CRC32_INIT;
                        crc_o    <= crc32_final(CRC32_INIT);
                        typ_o    <= '0;
                        len_o    <= '0;
                        err_pend <= ERR_OK;
                        rdy_o    <= 1'b1;
                        state    <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (acc) begin
                        len_o <= dat_i;
                        rem   <= dat_i;
                        if (dat_i > MAX_LEN) begin
                            err_pend <= ERR_LEN;
                            rdy_o    <= 1'b0;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_TYPE;
                        end
                    end
                end

`ifdef CRC_PAR4_EN
                ST_TYPE: begin
                    if (acc) begin
                        typ_o <= dat_i;
                        state <= (rem == 32'd0) ? ST_SCRC : ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (acc) begin
                        rem <= rem - {29'd0, nbytes};
                        if (rem <= 32'd4) begin
                            state <= ST_SCRC;
                        end
                    end
                end
`else
                ST_TYPE: begin
                    if (dig_en) begin
                        if (slot == 2'd0) begin
                            typ_o <= dat_i;
                            wbuf  <= dat_i[23:0];
                            rdy_o <= 1'b0;
                        end
                        if (slot == 2'd3) begin
                            rdy_o <= 1'b1;
                            state <= (rem == 32'd0) ? ST_SCRC : ST_DATA;
                        end
                        slot <= slot + 2'd1;
                    end
                end

                // Leaving on the last real byte skips the padding slots.
                ST_DATA: begin
                    if (dig_en) begin
                        if (slot == 2'd0) begin
                            wbuf <= dat_i[23:0];
                        end
                        rem <= rem - 32'd1;
                        if (rem == 32'd1) begin
                            rdy_o <= 1'b1;
                            slot  <= 2'd0;
                            state <= ST_SCRC;
                        end else begin
                            rdy_o <= (slot == 2'd3);
                            slot  <= slot + 2'd1;
                        end
                    end
                end
`endif

                ST_SCRC: begin
                    if (acc) begin
                        err_pend <= (dat_i == crc_o) ? ERR_OK : ERR_CRC;
                        rdy_o    <= 1'b0;
                        state    <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done_o     <= 1'b1;
                    err_o      <= (err_pend != ERR_OK);
                    err_code_o <= err_pend;
                    state      <= ST_IDLE;
                end

                default: begin
                    rdy_o <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_png_chunk_crc_chk.sv
// Self-checking bench for png_chunk_crc_chk: directed PNG chunks plus random chunks
// with random val_i gaps, checked against a byte-wise reflected CRC-32 reference.
module tb_png_chunk_crc_chk;

    localparam logic [31:0] MAX_LEN = 32'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        val_i = 1'b0;
    logic [31:0] dat_i = '0;
    logic        rdy_o, done_o, err_o;
    logic [1:0]  err_code_o;
    logic [31:0] typ_o, len_o, crc_o;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int exp_done = 0;

    png_chunk_crc_chk dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .val_i      (val_i),
        .dat_i      (dat_i),
        .rdy_o      (rdy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .typ_o      (typ_o),
        .len_o      (len_o),
        .crc_o      (crc_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_o) n_done++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Standard reflected CRC-32 (PNG/zlib), processed LSB-first on a shifting register.
    function automatic logic [31:0] crc_ref(input logic [7:0] bytes[$]);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        foreach (bytes[i]) begin
            r = r ^ {24'd0, bytes[i]};
            for (int b = 0; b < 8; b++) begin
                r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
            end
        end
        return ~r;
    endfunction

    task automatic send_word(input logic [31:0] w, input bit gaps, output int waited, output bit ok);
        int n;
        if (gaps) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                val_i = 1'b0;
                dat_i = $urandom;
                @(negedge clk);
            end
        end
        val_i  = 1'b1;
        dat_i  = w;
        waited = 0;
        ok     = 1'b1;
        while (!rdy_o) begin
            @(negedge clk);
            waited++;
            if (waited > 40) begin
                ok    = 1'b0;
                val_i = 1'b0;
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // auto_crc: stored CRC = reference CRC XOR scrc (scrc acts as a flip mask).
    task automatic run_chunk(input string tag, input logic [31:0] len, input logic [31:0] typ,
                             input logic [31:0] data[$], input bit auto_crc,
                             input logic [31:0] scrc, input bit gaps);
        logic [31:0] words[$];
        logic [7:0]  bytes[$];
        logic [31:0] exp_crc, stored, exp_typ;
        logic [1:0]  exp_code;
        int          nwords, left, waited, wsum, exp_wsum, lat, b;
        bit          ok, len_bad;

        len_bad  = (len > MAX_LEN);
        exp_wsum = 0;
        exp_typ  = '0;
        words.push_back(len);
        if (!len_bad) begin
            exp_typ = typ;
            words.push_back(typ);
            for (int k = 3; k >= 0; k--) bytes.push_back(typ[8*k +: 8]);
            left   = int'(len);
            nwords = (left + 3) / 4;
            exp_wsum = 3;
            for (int j = 0; j < nwords; j++) begin
                words.push_back(data[j]);
                b = (left > 4) ? 4 : left;
                if (j < nwords - 1 || b > 0) exp_wsum += b - 1;
                for (int k = 3; k >= 0; k--) begin
                    if (left > 0) begin
                        bytes.push_back(data[j][8*k +: 8]);
                        left--;
                    end
                end
            end
        end
        exp_crc = crc_ref(bytes);
        stored  = auto_crc ? (exp_crc ^ scrc) : scrc;
        if (!len_bad) words.push_back(stored);
        exp_code = len_bad ? 2'd2 : ((stored == exp_crc) ? 2'd0 : 2'd1);
`ifdef CRC_PAR4_EN
        exp_wsum = 0;
`endif

        do_start();
        wsum = 0;
        foreach (words[i]) begin
            send_word(words[i], gaps, waited, ok);
            if (!ok) begin
                chk($sformatf("%s handshake word %0d", tag, i), 32'(ok), 32'd1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            wsum += waited;
        end
        val_i = 1'b0;
        exp_done++;

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done_o && lat < 20);
        chk($sformatf("%s done latency", tag), 32'(lat), 32'd1);
        chk($sformatf("%s err", tag), 32'(err_o), 32'(exp_code != 2'd0));
        chk($sformatf("%s err_code", tag), 32'(err_code_o), 32'(exp_code));
        chk($sformatf("%s crc", tag), crc_o, exp_crc);
        chk($sformatf("%s typ", tag), typ_o, exp_typ);
        chk($sformatf("%s len", tag), len_o, len);
        chk($sformatf("%s rdy idle", tag), 32'(rdy_o), 32'd0);
        if (!gaps) chk($sformatf("%s rdy stall cycles", tag), 32'(wsum), 32'(exp_wsum));
        @(negedge clk);
        chk($sformatf("%s done pulse width", tag), 32'(done_o), 32'd0);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] len;
        int          w, dn;

        repeat (3) @(negedge clk);
        chk("reset rdy", 32'(rdy_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        chk("reset err", 32'(err_o), 32'd0);
        chk("reset err_code", 32'(err_code_o), 32'd0);
        chk("reset typ", typ_o, 32'd0);
        chk("reset len", len_o, 32'd0);
        chk("reset crc", crc_o, 32'd0);
        rst = 1'b0;

        q = {};
        run_chunk("iend", 32'd0, 32'h4945_4E44, q, 1'b0, 32'hAE42_6082, 1'b0);
        run_chunk("iend_bad", 32'd0, 32'h4945_4E44, q, 1'b0, 32'hAE42_6083, 1'b0);
        q = {32'h3536_3738, 32'h3900_0000};
        run_chunk("unaligned", 32'd5, 32'h3132_3334, q, 1'b0, 32'hCBF4_3926, 1'b0);
        q = {32'h3536_3738, 32'h39A5_5AC3};
        run_chunk("unaligned_pad", 32'd5, 32'h3132_3334, q, 1'b0, 32'hCBF4_3926, 1'b1);
        q = {};
        run_chunk("len_max", 32'h8000_0000, 32'h0, q, 1'b0, 32'h0, 1'b0);
        run_chunk("len_ffff", 32'hFFFF_FFFF, 32'h0, q, 1'b0, 32'h0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            len = 32'($urandom_range(0, 21));
            q = {};
            w = (int'(len) + 3) / 4;
            for (int j = 0; j < w; j++) q.push_back($urandom);
            run_chunk($sformatf("rand%0d", t), len, $urandom, q, 1'b1,
                      ($urandom_range(0, 2) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0,
                      t[0]);
        end

        // Abort mid-DATA: reset must clear everything and suppress done_o.
        do_start();
        begin
            int  wt;
            bit  okv;
            send_word(32'd12, 1'b0, wt, okv);
            send_word(32'h4944_4154, 1'b0, wt, okv);
            send_word(32'h0102_0304, 1'b0, wt, okv);
            val_i = 1'b0;
        end
        dn  = n_done;
        rst = 1'b1;
        @(negedge clk);
        chk("abort rdy", 32'(rdy_o), 32'd0);
        chk("abort done", 32'(done_o), 32'd0);
        chk("abort err", 32'(err_o), 32'd0);
        chk("abort err_code", 32'(err_code_o), 32'd0);
        chk("abort typ", typ_o, 32'd0);
        chk("abort len", len_o, 32'd0);
        chk("abort crc", crc_o, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort no done", 32'(n_done), 32'(dn));
        q = {};
        run_chunk("iend_after_abort", 32'd0, 32'h4945_4E44, q, 1'b0, 32'hAE42_6082, 1'b0);

        repeat (3) @(negedge clk);
        chk("done count", 32'(n_done), 32'(exp_done));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/png_chunk_crc_chk.md
Name: png_chunk_crc_chk

Overview:
- Receive-side checker for PNG chunks, the counterpart of the chunk CRC32 generator.
- Takes a word-aligned chunk stream: length, type, data, then stored CRC.
- Recomputes the PNG CRC-32 over type+data bytes and compares it with the stored CRC.
- Sits between the PNG stream reader and the IDAT/inflate path; reports chunk type, length, computed CRC and pass/fail per chunk.

Parameters:
- MAX_LEN, 32'h7FFF_FFFF: largest legal chunk length in bytes (PNG limit 2^31-1); a larger length is an error.
- DATA_WD, 32: input word width; fixed, not to be overridden.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start_i  input  1  begin a new chunk; honoured in IDLE only
- val_i  input  1  dat_i valid
- dat_i  input  32  chunk word; [31:24] is the first byte on the wire
- rdy_o  output  1  word accepted this cycle when val_i && rdy_o
- done_o  output  1  one-cycle pulse at end of chunk check
- err_o  output  1  valid with done_o; 1 = chunk failed
- err_code_o  output  2  valid with done_o: 0 OK, 1 CRC mismatch, 2 length > MAX_LEN
- typ_o  output  32  latched chunk type
- len_o  output  32  latched chunk length
- crc_o  output  32  computed CRC, final-XORed and reflected, matching the PNG field layout

Behaviour:
- Synchronous reset, active-high, on clk. Reset values:
  - FSM in IDLE.
  - rdy_o, done_o, err_o are 0; err_code_o is 0.
  - typ_o, len_o, crc_o are 0.
  - CRC register is 0.
- rst asserted mid-chunk aborts immediately: no done_o, and the partial chunk is discarded.
- Stream framing, each field word-aligned:
  - word 0 is the length.
  - word 1 is the type.
  - ceil(len/4) data words follow; unused low bytes of the last data word are padding and excluded from the CRC.
  - the final word is the stored CRC.
- CRC: polynomial 0x04C11DB7, init 0xFFFF_FFFF, byte input bit-reflected, result reflected then XORed with 0xFFFF_FFFF. One byte per cycle through an 8-bit combinational update.
- FSM states: IDLE, LEN, TYPE, DATA, SCRC, DONE.
  - IDLE: start_i loads CRC=FFFF_FFFF and moves to LEN. rdy_o is 0 in IDLE.
  - LEN: rdy_o=1.
    - On accept, latch len_o and a byte-remaining counter.
    - If len > MAX_LEN, go to DONE with code 2 (no further words consumed).
    - Otherwise go to TYPE.
  - TYPE / DATA: each accepted word is buffered and digested over 4 cycles (byte [31:24] in the accept cycle, then [23:16], [15:8], [7:0]).
    - rdy_o=1 only in the first slot, so a steady val_i sees rdy_o 1-0-0-0.
    - TYPE latches typ_o, then moves to DATA, or to SCRC if len==0.
    - DATA decrements the remaining count per byte. Padding-byte cycles are skipped.
    - The FSM leaves DATA for SCRC once the count reaches 0 after the last real byte.
  - SCRC: rdy_o=1 once the digest has finished. On accept, compare dat_i with crc_o, then go to DONE.
  - DONE: for one cycle assert done_o, err_o and err_code_o, then return to IDLE. typ_o, len_o and crc_o hold until the next start_i.
- Inputs are ignored when rdy_o=0. start_i outside IDLE is ignored.
- val_i may drop at any word boundary; the FSM waits in place.

Optional Feature:
- CRC_PAR4_EN defined:
  - A 32-bit parallel CRC update digests a whole word per cycle, so rdy_o=1 continuously in TYPE/DATA.
  - The last data word uses a 1/2/3/4-byte update selected by the remaining count.
- CRC_PAR4_EN undefined: byte-serial, 4 cycles per word, as above.
- Both variants produce identical crc_o and err results.

Decomposition:
- Shared package holds:
  - CRC32_POLY, CRC32_INIT, CRC32_XOROUT.
  - The FSM state encoding.
  - The err-code constants ERR_OK, ERR_CRC, ERR_LEN.
  - PNG_MAX_LEN.
- One sub-module, crc32_upd8: the combinational 8-bit CRC step.
  - The CRC_PAR4_EN build chains four crc32_upd8 instances.
  - The serial build uses one instance.

Test Plan:
- IEND: start, then 0x00000000, 0x49454E44, 0xAE426082 -> done_o after CRC accept, err_o=0, crc_o=0xAE426082, typ_o=0x49454E44.
- IEND with stored CRC 0xAE426083 -> done_o, err_o=1, err_code_o=1, crc_o=0xAE426082.
- Unaligned data: len 5, type 0x31323334 ("1234"), data 0x35363738, 0x39000000, CRC 0xCBF43926 -> err_o=0. Padding bytes must not affect the CRC.
- Length 0x80000000 -> done_o two cycles after the length accept, err_code_o=2; no further words accepted.
- Backpressure: val_i held 1 throughout -> rdy_o pattern 1,0,0,0 per type/data word (all 1 with CRC_PAR4_EN). Random val_i gaps give the same result.
- rst pulsed mid-DATA -> all outputs 0 next cycle, no done_o. A following clean IEND chunk passes.
